// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_ctrl
// Brief    : EX-stage multiply/divide sequencer owning HI/LO. Optional
//            MADD/MSUB accumulate ops are enabled by defining MDU_MADD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        discard,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] c_op_mult  = 3'd0;
    localparam logic [2:0] c_op_multu = 3'd1;
    localparam logic [2:0] c_op_div   = 3'd2;
    localparam logic [2:0] c_op_divu  = 3'd3;
    localparam logic [2:0] c_op_mthi  = 3'd4;
    localparam logic [2:0] c_op_mtlo  = 3'd5;
`ifdef MDU_MADD_EN
    localparam logic [2:0] c_op_madd  = 3'd6;
    localparam logic [2:0] c_op_msub  = 3'd7;
`endif

    localparam logic [5:0] c_mult_last = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] c_div_last  = 6'(DIV_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_p_hi;
    logic [31:0] r_p_lo;
    logic        r_busy;
    logic        r_done;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    assign w_prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign w_prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide runs on magnitudes; quotient/remainder signs fixed afterwards.
    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_div_zero;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_divisor;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;

    assign w_div_signed = (op == c_op_div);
    assign w_a_neg      = w_div_signed & rs[31];
    assign w_b_neg      = w_div_signed & rt[31];
    assign w_div_zero   = (rt == 32'd0);
    assign w_abs_a      = w_a_neg ? (~rs + 32'd1) : rs;
    assign w_abs_b      = w_b_neg ? (~rt + 32'd1) : rt;
    assign w_divisor    = w_div_zero ? 32'd1 : w_abs_b;
    assign w_uq         = w_abs_a / w_divisor;
    assign w_ur         = w_abs_a % w_divisor;
    assign w_q          = (w_a_neg ^ w_b_neg) ? (~w_uq + 32'd1) : w_uq;
    assign w_r          = w_a_neg ? (~w_ur + 32'd1) : w_ur;

`ifdef MDU_MADD_EN
    logic [63:0] w_acc_add;
    logic [63:0] w_acc_sub;
    assign w_acc_add = {r_hi, r_lo} + w_prod_s;
    assign w_acc_sub = {r_hi, r_lo} - w_prod_s;
`endif

    logic        w_is_long;
    logic [5:0]  w_cnt_init;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    always_comb begin
        w_is_long  = 1'b0;
        w_cnt_init = c_mult_last;
        w_res_hi   = 32'd0;
        w_res_lo   = 32'd0;
        case (op)
            c_op_mult: begin
                w_is_long = 1'b1;
                {w_res_hi, w_res_lo} = w_prod_s;
            end
            c_op_multu: begin
                w_is_long = 1'b1;
                {w_res_hi, w_res_lo} = w_prod_u;
            end
            c_op_div, c_op_divu: begin
                w_is_long  = 1'b1;
                w_cnt_init = c_div_last;
                w_res_hi   = w_div_zero ? rs : w_r;
                w_res_lo   = w_div_zero ? 32'hFFFF_FFFF : w_q;
            end
`ifdef MDU_MADD_EN
            c_op_madd: begin
                w_is_long = 1'b1;
                {w_res_hi, w_res_lo} = w_acc_add;
            end
            c_op_msub: begin
                w_is_long = 1'b1;
                {w_res_hi, w_res_lo} = w_acc_sub;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_p_hi  <= 32'd0;
            r_p_lo  <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !discard) begin
                        if (op == c_op_mthi) begin
                            r_hi <= rs;
                        end else if (op == c_op_mtlo) begin
                            r_lo <= rs;
                        end else if (w_is_long) begin
                            r_p_hi  <= w_res_hi;
                            r_p_lo  <= w_res_lo;
                            r_cnt   <= w_cnt_init;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // A cancel outranks completion in the same cycle.
                    if (discard) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= 6'd0;
                    end else if (r_cnt == 6'd0) begin
                        r_hi    <= r_p_hi;
                        r_lo    <= r_p_lo;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_ctrl
// Brief    : Directed self-checking bench for multdiv_ctrl (MDU_MADD_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_ctrl;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic        start   = 1'b0;
    logic        discard = 1'b0;
    logic [2:0]  op      = 3'd0;
    logic [31:0] rs      = 32'd0;
    logic [31:0] rt      = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int n;

    multdiv_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs      (rs),
        .rt      (rt),
        .discard (discard),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the request is sampled at the next rising edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        rs    = a;
        rt    = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1;
        chk("reset_hi",   hi,   32'd0);
        chk("reset_lo",   lo,   32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // MULT -2 * 3
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        chk("mult_busy_start", {31'd0, busy}, 32'd1);
        chk("mult_hi_held", hi, 32'd0);
        wait_idle(n);
        chk("mult_latency", n, 32'd5);
        chk("mult_done", {31'd0, done}, 32'd1);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        @(negedge clk);
        chk("mult_done_pulse", {31'd0, done}, 32'd0);

        // MULTU max * max
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("multu_latency", n, 32'd5);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        // DIV -7 / 2
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        chk("div_latency", n, 32'd10);
        chk("div_done", {31'd0, done}, 32'd1);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // DIV 7 / -2
        issue(3'd2, 32'd7, 32'hFFFF_FFFE);
        wait_idle(n);
        chk("div_neg_b_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_b_hi", hi, 32'd1);

        // DIVU 5 / 0
        issue(3'd3, 32'd5, 32'd0);
        wait_idle(n);
        chk("divu_z_lo", lo, 32'hFFFF_FFFF);
        chk("divu_z_hi", hi, 32'd5);

        // DIV -9 / 0
        issue(3'd2, 32'hFFFF_FFF7, 32'd0);
        wait_idle(n);
        chk("div_z_lo", lo, 32'hFFFF_FFFF);
        chk("div_z_hi", hi, 32'hFFFF_FFF7);

        // DIV overflow
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'd0);

        // DIVU large / small
        issue(3'd3, 32'hFFFF_FFF0, 32'd16);
        wait_idle(n);
        chk("divu_lo", lo, 32'h0FFF_FFFF);
        chk("divu_hi", hi, 32'd0);

        // Discard during RUN
        issue(3'd5, 32'h1234, 32'd0);
        chk("mtlo_lo", lo, 32'h1234);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        issue(3'd1, 32'd10, 32'd10);
        @(negedge clk);
        discard = 1'b1;
        @(negedge clk);
        discard = 1'b0;
        chk("discard_busy", {31'd0, busy}, 32'd0);
        chk("discard_done", {31'd0, done}, 32'd0);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
        chk("discard_no_done", n, 32'd0);
        chk("discard_lo", lo, 32'h1234);
        chk("discard_hi", hi, 32'd0);

        // Discard in IDLE blocks a start
        discard = 1'b1;
        issue(3'd4, 32'hDEAD, 32'd0);
        discard = 1'b0;
        chk("discard_idle_hi", hi, 32'd0);

        // Start while busy is ignored
        issue(3'd3, 32'd100, 32'd7);
        start = 1'b1;
        op    = 3'd4;
        rs    = 32'hAA;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignore_hi", hi, 32'd0);
        wait_idle(n);
        chk("divu100_latency", n, 32'd8);
        chk("divu100_hi", hi, 32'd2);
        chk("divu100_lo", lo, 32'd14);
        chk("divu100_done", {31'd0, done}, 32'd1);
        issue(3'd4, 32'hAA, 32'd0);
        chk("b2b_mthi", hi, 32'hAA);
        chk("b2b_busy", {31'd0, busy}, 32'd0);

        // Accumulate ops
        issue(3'd4, 32'd0, 32'd0);
        issue(3'd5, 32'd10, 32'd0);
        issue(3'd6, 32'd3, 32'd4);
`ifdef MDU_MADD_EN
        chk("madd_busy", {31'd0, busy}, 32'd1);
        wait_idle(n);
        chk("madd_latency", n, 32'd5);
        chk("madd_lo", lo, 32'd22);
        chk("madd_hi", hi, 32'd0);
        issue(3'd7, 32'd3, 32'd4);
        wait_idle(n);
        chk("msub_lo", lo, 32'd10);
        chk("msub_hi", hi, 32'd0);
        issue(3'd7, 32'd2, 32'd10);
        wait_idle(n);
        chk("msub_neg_lo", lo, 32'hFFFF_FFF6);
        chk("msub_neg_hi", hi, 32'hFFFF_FFFF);
`else
        chk("op6_busy", {31'd0, busy}, 32'd0);
        chk("op6_lo", lo, 32'd10);
        issue(3'd7, 32'd3, 32'd4);
        chk("op7_busy", {31'd0, busy}, 32'd0);
        chk("op7_lo", lo, 32'd10);
        chk("op7_hi", hi, 32'd0);
`endif

        // Reset mid-RUN
        issue(3'd4, 32'h55, 32'd0);
        issue(3'd0, 32'd7, 32'd9);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_run_busy", {31'd0, busy}, 32'd0);
        chk("rst_run_hi", hi, 32'd0);
        chk("rst_run_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        repeat (7) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n++;
        end
        chk("rst_run_idle", n, 32'd0);
        chk("rst_run_lo_after", lo, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
